// File: rtl/cache_ctrl_gen_if.sv
// Memory-side beat bus of the cache controller: the controller is the master,
// the memory (or its model) is the slave.
interface cache_ctrl_gen_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned MW = 8
);
  logic [AW-1:0] MADDR;
  logic          MREQ;
  logic          MWE;
  logic [MW-1:0] MDO;
  logic [MW-1:0] MDI;
  logic          MRDY;

  modport master (output MADDR, MREQ, MWE, MDO, input MDI, MRDY);
  modport slave  (input MADDR, MREQ, MWE, MDO, output MDI, MRDY);
endinterface

// File: rtl/cache_ctrl_gen.sv
// Write-through cache controller: single-entry request sequencing between a CPU
// port, a cache array port and a narrow beat-oriented memory bus.
module cache_ctrl_gen #(
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 8,
  parameter int unsigned AW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WE,
  input  logic            RREQ,
  input  logic [AW-1:0]   ADDR,
  input  logic [DW-1:0]   DIN,
  input  logic [1:0]      SIZE,
  input  logic            SIGNED,
  input  logic            CHIT,
  input  logic [1:0]      CSIZE,
  input  logic [DW-1:0]   CDOUT,
  output logic            CWE,
  output logic [DW+1:0]   CDIN,
  cache_ctrl_gen_if.master mem,
  output logic [DW-1:0]   DOUT,
  output logic            DONE,
  output logic            ERR,
  output logic            BUSY
);

  localparam int unsigned NB = DW / MW;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned MB = MW / 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, MREAD, FILL, MWRITE, RESP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   asm_q, asm_d;

  logic            cwe_d, mreq_d, mwe_d, done_d, err_d, busy_d;
  logic [DW+1:0]   cdin_d;
  logic [AW-1:0]   maddr_d;
  logic [MW-1:0]   mdo_d;
  logic [DW-1:0]   dout_d;
  logic            bad_c, last_c;

  // Keep the low 8<<sz bits; fill above with the access MSB when signed.
  function automatic logic [DW-1:0] extend(input logic [DW-1:0] x, input logic [1:0] sz,
                                           input logic sgn);
    logic [DW-1:0] r;
    logic          msb;
    int unsigned   nb;
    nb  = 32'd8 << sz;
    msb = 1'b0;
    r   = '0;
    for (int unsigned i = 0; i < DW; i++) if (i == nb - 32'd1) msb = x[i];
    for (int unsigned i = 0; i < DW; i++) r[i] = (i < nb) ? x[i] : (sgn & msb);
    return r;
  endfunction

  function automatic int unsigned beats(input logic [1:0] sz);
    int unsigned b;
    b = 32'd8 << sz;
    return (b > MW) ? b / MW : 32'd1;
  endfunction

  always_comb begin
    case (SIZE)
      2'd1:    bad_c = ADDR[0];
      2'd2:    bad_c = |ADDR[1:0];
      default: bad_c = 1'b0;
    endcase
    if (SIZE == 2'd3 || (32'd8 << SIZE) > DW) bad_c = 1'b1;
  end

  assign last_c = (32'(beat_q) == beats(size_q) - 32'd1);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    din_d   = din_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wr_d    = wr_q;
    asm_d   = asm_q;
    cwe_d   = 1'b0;
    cdin_d  = CDIN;
    dout_d  = DOUT;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (WE || RREQ) begin
          addr_d = ADDR;
          din_d  = DIN;
          size_d = SIZE;
          sgn_d  = SIGNED;
          wr_d   = WE;
          beat_d = '0;
          asm_d  = '0;
          if (bad_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = LOOKUP;
            if (WE) begin
              cwe_d  = 1'b1;
              cdin_d = {SIZE, extend(DIN, SIZE, 1'b0)};
            end
          end
        end
      end
      // Writes spend this cycle on the cache strobe; reads probe the cache.
      LOOKUP: begin
        if (wr_q) begin
          state_d = MWRITE;
        end else if (CHIT && CSIZE >= size_q) begin
          dout_d  = extend(CDOUT, size_q, sgn_q);
          state_d = RESP;
        end else begin
          state_d = MREAD;
        end
      end
      MREAD: begin
        if (mem.MRDY) begin
          asm_d[32'(beat_q) * MW +: MW] = mem.MDI;
          if (last_c) begin
            state_d = FILL;
            dout_d  = extend(asm_d, size_q, sgn_q);
            cwe_d   = 1'b1;
            cdin_d  = {size_q, extend(asm_d, size_q, sgn_q)};
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      FILL: state_d = RESP;
      MWRITE: begin
        if (mem.MRDY) begin
          if (last_c) state_d = RESP;
          else        beat_d  = beat_q + BW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered images of the state being entered.
    mreq_d  = (state_d == MREAD) || (state_d == MWRITE);
    mwe_d   = (state_d == MWRITE);
    maddr_d = addr_d + AW'(beat_d) * AW'(MB);
    mdo_d   = (state_d == MWRITE) ? din_d[32'(beat_d) * MW +: MW] : '0;
    done_d  = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      wr_q      <= 1'b0;
      asm_q     <= '0;
      CWE       <= 1'b0;
      CDIN      <= '0;
      mem.MADDR <= '0;
      mem.MREQ  <= 1'b0;
      mem.MWE   <= 1'b0;
      mem.MDO   <= '0;
      DOUT      <= '0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      wr_q      <= wr_d;
      asm_q     <= asm_d;
      CWE       <= cwe_d;
      CDIN      <= cdin_d;
      mem.MADDR <= maddr_d;
      mem.MREQ  <= mreq_d;
      mem.MWE   <= mwe_d;
      mem.MDO   <= mdo_d;
      DOUT      <= dout_d;
      DONE      <= done_d;
      ERR       <= err_d;
      BUSY      <= busy_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_gen.sv
// Directed bench for cache_ctrl_gen (DW=32, MW=8): vector table plus reset sequences,
// with a byte-wide memory responder that can insert MRDY wait cycles.
module tb_cache_ctrl_gen;

  logic        CLK, RST, WE, RREQ, SIGNED, CHIT, CWE, DONE, ERR, BUSY;
  logic [31:0] ADDR, DIN, CDOUT, DOUT;
  logic [1:0]  SIZE, CSIZE;
  logic [33:0] CDIN;

  cache_ctrl_gen_if #(.AW(32), .MW(8)) mif ();

  cache_ctrl_gen #(.DW(32), .MW(8), .AW(32)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .RREQ(RREQ), .ADDR(ADDR), .DIN(DIN),
    .SIZE(SIZE), .SIGNED(SIGNED), .CHIT(CHIT), .CSIZE(CSIZE), .CDOUT(CDOUT),
    .CWE(CWE), .CDIN(CDIN), .mem(mif), .DOUT(DOUT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we, rreq;
    logic [31:0] addr, din;
    logic [1:0]  size;
    logic        sgn, chit;
    logic [1:0]  csize;
    logic [31:0] cdout, rd;
    int          stall;
    logic [31:0] e_dout;
    logic        e_err, e_cwe;
    logic [33:0] e_cdin;
    logic        e_mreq;
    int          e_wn, e_lat;
  } vec_t;

  int n_chk = 0, n_fail = 0;

  // memory responder state
  int          stall_cfg = 0, stall_cnt = 0, wcnt = 0, rbeats = 0;
  logic [31:0] cur_rd = '0, cur_base = '0;
  logic [31:0] wl_addr [8];
  logic [7:0]  wl_data [8];
  logic        prev_req, prev_rdy;
  logic [31:0] prev_addr;
  logic [7:0]  prev_mdo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    int off;
    mif.MRDY = 1'b0;
    mif.MDI  = '0;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    prev_addr = '0;
    prev_mdo = '0;
    forever begin
      @(negedge CLK);
      if (mif.MREQ && prev_req && !prev_rdy) begin
        chk("maddr_stable", 64'(mif.MADDR), 64'(prev_addr));
        chk("mdo_stable", 64'(mif.MDO), 64'(prev_mdo));
      end
      prev_req  = mif.MREQ;
      prev_addr = mif.MADDR;
      prev_mdo  = mif.MDO;
      if (mif.MREQ) begin
        if (stall_cnt < stall_cfg) begin
          mif.MRDY = 1'b0;
          stall_cnt++;
        end else begin
          mif.MRDY  = 1'b1;
          stall_cnt = 0;
          off = int'(mif.MADDR - cur_base);
          if (mif.MWE) begin
            if (wcnt < 8) begin
              wl_addr[wcnt] = mif.MADDR;
              wl_data[wcnt] = mif.MDO;
            end
            wcnt++;
          end else begin
            rbeats++;
            mif.MDI = (off >= 0 && off < 4) ? cur_rd[off*8 +: 8] : 8'h00;
          end
        end
      end else begin
        mif.MRDY  = 1'b0;
        stall_cnt = 0;
      end
      prev_rdy = mif.MRDY;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({CWE, mif.MREQ, mif.MWE, DONE, ERR, BUSY}), 64'(0));
    chk({tag, "_dout"}, 64'(DOUT), 64'(0));
    chk({tag, "_maddr"}, 64'(mif.MADDR), 64'(0));
    chk({tag, "_mdo"}, 64'(mif.MDO), 64'(0));
    chk({tag, "_cdin"}, 64'(CDIN), 64'(0));
  endtask

  // Issue one request, scramble the request inputs after acceptance, observe to DONE.
  task automatic run_vec(input vec_t v, input string nm);
    int          cyc, ncwe, lat;
    logic        seen, mseen, eq;
    logic [33:0] cd;
    logic [31:0] dq;
    @(negedge CLK);
    WE = v.we; RREQ = v.rreq; ADDR = v.addr; DIN = v.din; SIZE = v.size; SIGNED = v.sgn;
    CHIT = v.chit; CSIZE = v.csize; CDOUT = v.cdout;
    cur_rd = v.rd; cur_base = v.addr; stall_cfg = v.stall; wcnt = 0;
    @(negedge CLK);
    WE = 1'b0; RREQ = 1'b0; ADDR = ~v.addr; DIN = ~v.din; SIZE = 2'd3; SIGNED = ~v.sgn;
    chk({nm, "_busy"}, 64'(BUSY), 64'(1));
    cyc = 1; ncwe = 0; seen = 1'b0; mseen = 1'b0; lat = 0; cd = '0; dq = '0; eq = 1'b0;
    while (!seen && cyc <= 200) begin
      if (CWE) begin ncwe++; cd = CDIN; end
      if (mif.MREQ) mseen = 1'b1;
      if (DONE) begin
        seen = 1'b1; lat = cyc; dq = DOUT; eq = ERR;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'(1));
    chk({nm, "_latency"}, 64'(lat), 64'(v.e_lat));
    chk({nm, "_dout"}, 64'(dq), 64'(v.e_dout));
    chk({nm, "_err"}, 64'(eq), 64'(v.e_err));
    chk({nm, "_cwe_pulses"}, 64'(ncwe), 64'(v.e_cwe));
    if (v.e_cwe) chk({nm, "_cdin"}, 64'(cd), 64'(v.e_cdin));
    chk({nm, "_mreq_seen"}, 64'(mseen), 64'(v.e_mreq));
    chk({nm, "_wbeats"}, 64'(wcnt), 64'(v.e_wn));
    for (int k = 0; k < v.e_wn && k < 8; k++) begin
      chk({nm, "_waddr"}, 64'(wl_addr[k]), 64'(v.addr + 32'(k)));
      chk({nm, "_wdata"}, 64'(wl_data[k]), 64'(v.din[k*8 +: 8]));
    end
    @(negedge CLK);
    chk({nm, "_done_one_cycle"}, 64'({DONE, BUSY, CWE}), 64'(0));
  endtask

  vec_t vt [15];

  initial begin
    int   cyc, ncwe, ndone;
    vec_t rv;
    vt[0]  = '{1'b0,1'b1,32'h100,32'h0,2'd2,1'b0,1'b1,2'd2,32'hDEADBEEF,32'h0,0, 32'hDEADBEEF,1'b0,1'b0,34'h0,1'b0,0,2};
    vt[1]  = '{1'b0,1'b1,32'h100,32'h0,2'd0,1'b1,1'b0,2'd0,32'h0,32'h80,0, 32'hFFFFFF80,1'b0,1'b1,34'h0_FFFFFF80,1'b1,0,4};
    vt[2]  = '{1'b1,1'b0,32'h200,32'h11223344,2'd2,1'b0,1'b0,2'd0,32'h0,32'h0,2, 32'hFFFFFF80,1'b0,1'b1,34'h2_11223344,1'b1,4,14};
    vt[3]  = '{1'b0,1'b1,32'h102,32'h0,2'd2,1'b0,1'b1,2'd2,32'h55555555,32'h0,0, 32'hFFFFFF80,1'b1,1'b0,34'h0,1'b0,0,1};
    vt[4]  = '{1'b1,1'b1,32'h300,32'hAABBCCDD,2'd1,1'b0,1'b0,2'd0,32'h0,32'h0,0, 32'hFFFFFF80,1'b0,1'b1,34'h1_0000CCDD,1'b1,2,4};
    vt[5]  = '{1'b0,1'b1,32'h104,32'h0,2'd1,1'b0,1'b0,2'd0,32'h0,32'h8001,0, 32'h00008001,1'b0,1'b1,34'h1_00008001,1'b1,0,5};
    vt[6]  = '{1'b0,1'b1,32'h106,32'h0,2'd1,1'b1,1'b0,2'd0,32'h0,32'h8001,0, 32'hFFFF8001,1'b0,1'b1,34'h1_FFFF8001,1'b1,0,5};
    vt[7]  = '{1'b0,1'b1,32'h108,32'h0,2'd2,1'b0,1'b1,2'd0,32'h99999999,32'h12345678,0, 32'h12345678,1'b0,1'b1,34'h2_12345678,1'b1,0,7};
    vt[8]  = '{1'b0,1'b1,32'h101,32'h0,2'd0,1'b1,1'b1,2'd2,32'h123456F0,32'h0,0, 32'hFFFFFFF0,1'b0,1'b0,34'h0,1'b0,0,2};
    vt[9]  = '{1'b0,1'b1,32'h0,32'h0,2'd3,1'b0,1'b1,2'd2,32'h0,32'h0,0, 32'hFFFFFFF0,1'b1,1'b0,34'h0,1'b0,0,1};
    vt[10] = '{1'b1,1'b0,32'h103,32'h1234,2'd1,1'b0,1'b0,2'd0,32'h0,32'h0,0, 32'hFFFFFFF0,1'b1,1'b0,34'h0,1'b0,0,1};
    vt[11] = '{1'b0,1'b1,32'h10C,32'h0,2'd0,1'b1,1'b1,2'd0,32'hAAAAAA7F,32'h0,0, 32'h0000007F,1'b0,1'b0,34'h0,1'b0,0,2};
    vt[12] = '{1'b1,1'b0,32'h400,32'hFFFFFF5A,2'd0,1'b0,1'b0,2'd0,32'h0,32'h0,0, 32'h0000007F,1'b0,1'b1,34'h0_0000005A,1'b1,1,3};
    vt[13] = '{1'b0,1'b1,32'h123,32'h0,2'd0,1'b0,1'b0,2'd0,32'h0,32'hC3,3, 32'h000000C3,1'b0,1'b1,34'h0_000000C3,1'b1,0,7};
    vt[14] = '{1'b0,1'b1,32'h500,32'h0,2'd2,1'b0,1'b0,2'd0,32'h0,32'hCAFEF00D,0, 32'hCAFEF00D,1'b0,1'b1,34'h2_CAFEF00D,1'b1,0,7};

    RST = 1'b1; WE = 1'b0; RREQ = 1'b0; ADDR = '0; DIN = '0; SIZE = '0; SIGNED = 1'b0;
    CHIT = 1'b0; CSIZE = '0; CDOUT = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset during a four-beat miss, right after the first beat completes.
    rbeats = 0;
    @(negedge CLK);
    RREQ = 1'b1; ADDR = 32'h500; SIZE = 2'd2; SIGNED = 1'b0; CHIT = 1'b0;
    cur_base = 32'h500; cur_rd = 32'hCAFEF00D; stall_cfg = 1;
    @(negedge CLK);
    RREQ = 1'b0;
    cyc = 0;
    while (rbeats < 1 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    chk("midrst_first_beat", 64'(rbeats), 64'(1));
    @(negedge CLK);
    chk("midrst_in_flight", 64'({mif.MREQ, BUSY}), 64'(3));
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("midrst");
    RST = 1'b0;
    ncwe = 0; ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (CWE) ncwe++;
      if (DONE) ndone++;
    end
    chk("midrst_no_cwe", 64'(ncwe), 64'(0));
    chk("midrst_no_done", 64'(ndone), 64'(0));
    chk("midrst_idle", 64'({BUSY, mif.MREQ}), 64'(0));

    rv = vt[14];
    run_vec(rv, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_gen.md
CACHE_CTRL_GEN -- requirements
Module: cache_ctrl_gen

Interface
REQ-001 SHALL have parameter DW, default 32, CPU/cache data width in bits (multiple of 8).
REQ-002 SHALL have parameter MW, default 8, memory beat width in bits (multiple of 8, divides DW).
REQ-003 SHALL have parameter AW, default 32, byte-address width.
REQ-004 SHALL have port CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port RST  in  1  synchronous active-high reset.
REQ-006 SHALL have ports WE/RREQ  in  1/1  write request / read request, sampled only in IDLE.
REQ-007 SHALL have ports ADDR/DIN  in  AW/DW  byte address / write data, right-aligned.
REQ-008 SHALL have ports SIZE/SIGNED  in  2/1  access size (0 byte, 1 half, 2 word) / sign-extend reads.
REQ-009 SHALL have ports CHIT/CSIZE/CDOUT  in  1/2/DW  cache hit, stored size, stored data.
REQ-010 SHALL have ports CWE/CDIN  out  1/2+DW  cache write strobe / {size, data}.
REQ-011 SHALL have ports MADDR/MREQ/MWE/MDO  out  AW/1/1/MW  beat address, request, write enable, write data.
REQ-012 SHALL have ports MDI/MRDY  in  MW/1  read data / beat-complete.
REQ-013 SHALL have ports DOUT/DONE/ERR/BUSY  out  DW/1/1/1  read result, completion pulse, misalignment error, not-idle.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, MREAD, FILL, MWRITE, RESP; unused encodings go to IDLE.
REQ-015 SHALL latch ADDR, DIN, SIZE, SIGNED at the accepting edge; later input changes have no effect on the operation.
REQ-016 SHALL give WE priority over RREQ when both are high in IDLE; requests outside IDLE are ignored, not queued.
REQ-017 SHALL compute access bytes B = 1<<SIZE and beats N = max(1, 8B/MW); SIZE=3 or 8B>DW is an error.
REQ-018 SHALL flag misalignment when ADDR mod B != 0; error or misalignment -> RESP with ERR=1, DONE=1, no cache or memory activity.
REQ-019 SHALL, on accepted write, pulse CWE for one cycle with CDIN={SIZE, DIN masked to 8B bits}, then enter MWRITE (write-through).
REQ-020 SHALL in MWRITE hold MREQ=MWE=1, MADDR=base+beat*(MW/8), MDO=DIN bits [beat*MW +: MW]; advance beat on MRDY; RESP after beat N-1.
REQ-021 SHALL on accepted read enter LOOKUP; at next edge CHIT=1 and CSIZE>=SIZE -> DOUT=extend(CDOUT), RESP; else MREAD.
REQ-022 SHALL in MREAD hold MREQ=1, MWE=0, same MADDR rule; on MRDY store MDI into beat slot; FILL after beat N-1.
REQ-023 SHALL in FILL set DOUT=extend(assembled) and pulse CWE one cycle with CDIN={SIZE, extend(assembled)}, then RESP.
REQ-024 SHALL define extend(x): low 8B bits kept, upper bits = SIGNED & x[8B-1], else zero.
REQ-025 SHALL in RESP assert DONE for exactly one cycle, return to IDLE; DOUT holds until next read completes.
REQ-026 SHALL tolerate arbitrary MRDY wait cycles; MADDR/MDO stable while MREQ=1 and MRDY=0.
REQ-027 SHALL give latency: hit read DONE 2 cycles after accept; miss read N+3 cycles with MRDY tied high; write N+2.
REQ-028 SHALL assert BUSY in every state except IDLE.
REQ-029 SHALL ignore MRDY when MREQ=0.

Reset
REQ-030 SHALL on RST, in any state, enter IDLE at that edge, clearing beat counter; CWE, MREQ, MWE, DONE, ERR, BUSY = 0; DOUT, MADDR, MDO, CDIN = 0.
REQ-031 SHALL abandon an in-flight access on RST with no DONE and no further CWE pulse.

Verification
REQ-032 Hit: RREQ, ADDR=0x100, SIZE=2, CHIT=1, CSIZE=2, CDOUT=0xDEADBEEF -> DOUT=0xDEADBEEF, DONE pulse 2 cycles after accept, MREQ never high.
REQ-033 Miss signed byte: RREQ, SIZE=0, SIGNED=1, CHIT=0, MDI=0x80 -> one beat at 0x100, DOUT=0xFFFFFF80, CDIN={0,0xFFFFFF80}, CWE one cycle.
REQ-034 Write word, MW=8: WE, ADDR=0x200, DIN=0x11223344 -> CWE pulse, MDO 0x44,0x33,0x22,0x11 at 0x200..0x203, MRDY stalls of 2 cycles honoured, single DONE.
REQ-035 Misaligned: RREQ, ADDR=0x102, SIZE=2 -> ERR=1 and DONE=1 same cycle, CWE=0, MREQ=0.
REQ-036 Reset mid-miss: assert RST after beat 1 of 4 -> IDLE next cycle, all outputs zero, no CWE, no DONE; next request completes normally.
REQ-037 Collision: WE and RREQ high together in IDLE -> write performed, read ignored; half-word unsigned miss read 0x8001 -> DOUT=0x00008001.
